board_controller: RTL and testbench

//  Sequencer and owner of the 5x5 game board driven into the VGA datapath.
//  It turns cursor-move and place pulses into cell writes and alternates the two players.
//  It scans for a winning line, detects a full board, and publishes a frame-stable display copy.
//  The display copy updates only at vsync assertion, so the pixel path never shows a torn board.

---
 rtl/game_pkg.sv | 25 ++
 rtl/board_controller_if.sv | 30 +++
 rtl/line_check.sv | 16 +
 rtl/board_controller.sv | 198 +++++++++++++++++++
 tb/tb_board_controller.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// Shared types and the line table for the 5x5 board controller.
package game_pkg;
   localparam int N     = 5;
   localparam int CELLS = N * N;
   localparam int LINES = 2 * N + 2;

   typedef enum logic [1:0] {EMPTY = 2'b00, P1 = 2'b01, P2 = 2'b10} cell_t;
   typedef enum logic [2:0] {IDLE, CHECK, WRITE, SCAN, OVER} state_t;

   // Rows 0-4, columns 5-9, main diagonal 10, anti-diagonal 11.
   localparam logic [4:0] LINE_TBL [LINES][N] = '{
      '{5'd0,  5'd1,  5'd2,  5'd3,  5'd4 },
      '{5'd5,  5'd6,  5'd7,  5'd8,  5'd9 },
      '{5'd10, 5'd11, 5'd12, 5'd13, 5'd14},
      '{5'd15, 5'd16, 5'd17, 5'd18, 5'd19},
      '{5'd20, 5'd21, 5'd22, 5'd23, 5'd24},
      '{5'd0,  5'd5,  5'd10, 5'd15, 5'd20},
      '{5'd1,  5'd6,  5'd11, 5'd16, 5'd21},
      '{5'd2,  5'd7,  5'd12, 5'd17, 5'd22},
      '{5'd3,  5'd8,  5'd13, 5'd18, 5'd23},
      '{5'd4,  5'd9,  5'd14, 5'd19, 5'd24},
      '{5'd0,  5'd6,  5'd12, 5'd18, 5'd24},
      '{5'd4,  5'd8,  5'd12, 5'd16, 5'd20}
   };
endpackage

// File: rtl/board_controller_if.sv
// Control pulses in, frame-stable board/cursor and game status out.
interface board_controller_if;
   import game_pkg::*;

   logic                   place;
   logic                   mv_left;
   logic                   mv_right;
   logic                   mv_up;
   logic                   mv_down;
   logic                   new_game;
   logic                   vsync;
   logic [2*CELLS-1:0]     board_disp;
   logic [4:0]             cursor_disp;
   logic                   turn;
   logic                   playerwin;
   logic                   player2win;
   logic                   is_full;
   logic                   reject;
   logic                   busy;

   modport master (
      output place, mv_left, mv_right, mv_up, mv_down, new_game, vsync,
      input  board_disp, cursor_disp, turn, playerwin, player2win, is_full, reject, busy
   );

   modport slave (
      input  place, mv_left, mv_right, mv_up, mv_down, new_game, vsync,
      output board_disp, cursor_disp, turn, playerwin, player2win, is_full, reject, busy
   );
endinterface

// File: rtl/line_check.sv
// Combinational test: are all five cells of one line owned by the mover?
module line_check
   import game_pkg::*;
(
   input  logic [2*N-1:0] cells,
   input  cell_t          code,
   output logic           hit
);
   logic [N-1:0] eq;

   for (genvar k = 0; k < N; k++) begin : g_eq
      assign eq[k] = (cells[2*k +: 2] == code);
   end

   assign hit = &eq;
endmodule

// File: rtl/board_controller.sv
// Game sequencer: cursor, cell writes, turn alternation, line scan and
// a display copy of board/cursor refreshed only on vsync assertion.
module board_controller
   import game_pkg::*;
#(
   parameter logic       FIRST_PLAYER = 1'b0,
   parameter logic [4:0] CURSOR_HOME  = 5'd12
) (
   input  logic               clk,
   input  logic               reset,
   board_controller_if.slave  bus
);
   localparam logic [2:0] HOME_ROW  = 3'(CURSOR_HOME / 5'd5);
   localparam logic [2:0] HOME_COL  = 3'(CURSOR_HOME % 5'd5);
   localparam logic [2:0] LAST      = 3'(N - 1);
   localparam logic [3:0] LAST_LINE = 4'(LINES - 1);

   state_t             state, state_nx;
   logic [2*CELLS-1:0] board;
   logic [2:0]         cur_row, cur_col;
   logic [4:0]         cur_idx;
   logic [4:0]         pos_p0;
   logic [3:0]         line_idx;
   logic               turn, pwin, p2win, full_flag, reject;
   logic               vsync_p1, disp_upd_p1;
   logic [2*CELLS-1:0] board_disp;
   logic [4:0]         cursor_disp;

   logic [2*N-1:0]     line_cells;
   logic [CELLS-1:0]   occ;
   logic               hit, all_occ, cell_occ;
   cell_t              code;

   logic reject_nx, latch_en, write_en, scan_clr, scan_inc;
   logic win_set, full_set, turn_tgl;

   assign cur_idx  = ({2'b00, cur_row} << 2) + {2'b00, cur_row} + {2'b00, cur_col};
   assign code     = turn ? P2 : P1;

   for (genvar g = 0; g < CELLS; g++) begin : g_occ
      assign occ[g] = |board[2*g +: 2];
   end
   assign all_occ  = &occ;
   assign cell_occ = occ[pos_p0];

   for (genvar k = 0; k < N; k++) begin : g_line
      assign line_cells[2*k +: 2] = board[{LINE_TBL[line_idx][k], 1'b0} +: 2];
   end

   line_check u_line_check (
      .cells (line_cells),
      .code  (code),
      .hit   (hit)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      reject_nx = 1'b0;
      latch_en  = 1'b0;
      write_en  = 1'b0;
      scan_clr  = 1'b0;
      scan_inc  = 1'b0;
      win_set   = 1'b0;
      full_set  = 1'b0;
      turn_tgl  = 1'b0;
      case (state)
         IDLE: begin
            if (bus.place) begin
               latch_en = 1'b1;
               state_nx = CHECK;
            end
         end
         CHECK: begin
            reject_nx = bus.place | cell_occ;
            state_nx  = cell_occ ? IDLE : WRITE;
         end
         WRITE: begin
            reject_nx = bus.place;
            write_en  = 1'b1;
            scan_clr  = 1'b1;
            state_nx  = SCAN;
         end
         SCAN: begin
            reject_nx = bus.place;
            if (hit) begin
               win_set  = 1'b1;
               state_nx = OVER;
            end else if (line_idx == LAST_LINE) begin
               if (all_occ) begin
                  full_set = 1'b1;
                  state_nx = OVER;
               end else begin
                  turn_tgl = 1'b1;
                  state_nx = IDLE;
               end
            end else begin
               scan_inc = 1'b1;
            end
         end
         OVER:    reject_nx = bus.place;
         default: state_nx  = IDLE;
      endcase
      // new_game overrides whatever the current state wanted to do
      if (bus.new_game) begin
         state_nx  = IDLE;
         reject_nx = 1'b0;
         latch_en  = 1'b0;
         write_en  = 1'b0;
         win_set   = 1'b0;
         full_set  = 1'b0;
         turn_tgl  = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         board     <= '0;
         turn      <= FIRST_PLAYER;
         pwin      <= 1'b0;
         p2win     <= 1'b0;
         full_flag <= 1'b0;
         reject    <= 1'b0;
         pos_p0    <= '0;
         line_idx  <= '0;
      end else if (bus.new_game) begin
         board     <= '0;
         turn      <= FIRST_PLAYER;
         pwin      <= 1'b0;
         p2win     <= 1'b0;
         full_flag <= 1'b0;
         reject    <= 1'b0;
         line_idx  <= '0;
      end else begin
         reject <= reject_nx;
         if (latch_en) pos_p0 <= cur_idx;
         if (write_en) board[{pos_p0, 1'b0} +: 2] <= code;
         if (scan_clr)      line_idx <= '0;
         else if (scan_inc) line_idx <= line_idx + 4'd1;
         if (win_set) begin
            if (turn) p2win <= 1'b1;
            else      pwin  <= 1'b1;
         end
         if (full_set) full_flag <= 1'b1;
         if (turn_tgl) turn <= ~turn;
      end
   end

   // Row and column wrap independently; opposite moves cancel.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cur_row <= HOME_ROW;
         cur_col <= HOME_COL;
      end else if (bus.new_game) begin
         cur_row <= HOME_ROW;
         cur_col <= HOME_COL;
      end else if (state != OVER) begin
         if (bus.mv_right && !bus.mv_left)
            cur_col <= (cur_col == LAST) ? 3'd0 : cur_col + 3'd1;
         else if (bus.mv_left && !bus.mv_right)
            cur_col <= (cur_col == 3'd0) ? LAST : cur_col - 3'd1;
         if (bus.mv_down && !bus.mv_up)
            cur_row <= (cur_row == LAST) ? 3'd0 : cur_row + 3'd1;
         else if (bus.mv_up && !bus.mv_down)
            cur_row <= (cur_row == 3'd0) ? LAST : cur_row - 3'd1;
      end
   end

   // Display stage: fall of vsync seen at _p1, copy taken the cycle after.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vsync_p1    <= 1'b1;
         disp_upd_p1 <= 1'b0;
         board_disp  <= '0;
         cursor_disp <= CURSOR_HOME;
      end else begin
         vsync_p1    <= bus.vsync;
         disp_upd_p1 <= vsync_p1 & ~bus.vsync;
         if (disp_upd_p1) begin
            board_disp  <= board;
            cursor_disp <= cur_idx;
         end
      end
   end

   assign bus.board_disp  = board_disp;
   assign bus.cursor_disp = cursor_disp;
   assign bus.turn        = turn;
   assign bus.playerwin   = pwin;
   assign bus.player2win  = p2win;
   assign bus.is_full     = full_flag;
   assign bus.reject      = reject;
   assign bus.busy        = (state != IDLE);
endmodule

// File: tb/tb_board_controller.sv
// Bench for board_controller: directed games plus random play against a move-level model.
module tb_board_controller;
   localparam int WIN = 18;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   board_controller_if bus();

   board_controller dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;

   int m_cell [25];
   int m_row, m_col;
   bit m_turn, m_pwin, m_p2win, m_full, m_over;
   logic [49:0] disp_snap;
   logic [4:0]  cur_snap;

   int row_game [9]  = '{0, 5, 1, 6, 2, 7, 3, 8, 4};
   int draw_pat [25] = '{1,1,2,2,1, 2,2,1,1,2, 1,1,2,2,1, 2,2,1,1,2, 1,1,2,2,1};
   int q1 [$];
   int q2 [$];

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int m_cur();
      return m_row * 5 + m_col;
   endfunction

   function automatic logic [49:0] m_pack();
      logic [49:0] v;
      v = '0;
      for (int i = 0; i < 25; i++) v[2*i +: 2] = 2'(m_cell[i]);
      return v;
   endfunction

   function automatic bit m_line_win(input int code);
      bit w;
      for (int r = 0; r < 5; r++) begin
         w = 1'b1;
         for (int c = 0; c < 5; c++) if (m_cell[r*5+c] != code) w = 1'b0;
         if (w) return 1'b1;
      end
      for (int c = 0; c < 5; c++) begin
         w = 1'b1;
         for (int r = 0; r < 5; r++) if (m_cell[r*5+c] != code) w = 1'b0;
         if (w) return 1'b1;
      end
      w = 1'b1;
      for (int k = 0; k < 5; k++) if (m_cell[k*6] != code) w = 1'b0;
      if (w) return 1'b1;
      w = 1'b1;
      for (int k = 0; k < 5; k++) if (m_cell[4+k*4] != code) w = 1'b0;
      return w;
   endfunction

   function automatic bit m_board_full();
      for (int i = 0; i < 25; i++) if (m_cell[i] == 0) return 1'b0;
      return 1'b1;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 25; i++) m_cell[i] = 0;
      m_row = 2; m_col = 2;
      m_turn = 1'b0; m_pwin = 1'b0; m_p2win = 1'b0; m_full = 1'b0; m_over = 1'b0;
   endtask

   task automatic check_flags(input string tag);
      check_eq({tag, ".turn"},  64'(bus.turn),       64'(m_turn));
      check_eq({tag, ".p1win"}, 64'(bus.playerwin),  64'(m_pwin));
      check_eq({tag, ".p2win"}, 64'(bus.player2win), 64'(m_p2win));
      check_eq({tag, ".full"},  64'(bus.is_full),    64'(m_full));
   endtask

   task automatic do_move(input bit l, input bit r, input bit u, input bit d);
      @(negedge clk);
      bus.mv_left = l; bus.mv_right = r; bus.mv_up = u; bus.mv_down = d;
      @(negedge clk);
      bus.mv_left = 1'b0; bus.mv_right = 1'b0; bus.mv_up = 1'b0; bus.mv_down = 1'b0;
      if (!m_over) begin
         if (r && !l)      m_col = (m_col + 1) % 5;
         else if (l && !r) m_col = (m_col + 4) % 5;
         if (d && !u)      m_row = (m_row + 1) % 5;
         else if (u && !d) m_row = (m_row + 4) % 5;
      end
   endtask

   task automatic goto_cell(input int target);
      for (int n = 0; n < 12 && m_cur() != target; n++) begin
         if (m_col != target % 5) do_move(1'b0, 1'b1, 1'b0, 1'b0);
         else                     do_move(1'b0, 1'b0, 1'b0, 1'b1);
      end
   endtask

   task automatic do_vsync(input string tag);
      @(negedge clk);
      bus.vsync = 1'b0;
      repeat (3) @(negedge clk);
      bus.vsync = 1'b1;
      repeat (2) @(negedge clk);
      disp_snap = m_pack();
      cur_snap  = 5'(m_cur());
      check_eq({tag, ".board_disp"},  64'(bus.board_disp),  64'(disp_snap));
      check_eq({tag, ".cursor_disp"}, 64'(bus.cursor_disp), 64'(cur_snap));
   endtask

   task automatic do_place(input string tag, input bit extra);
      int busy_cnt, rej_cnt, exp_busy, exp_rej, idx, code;
      @(negedge clk);
      bus.place = 1'b1;
      @(negedge clk);
      bus.place = 1'b0;
      busy_cnt = 0;
      rej_cnt  = 0;
      for (int i = 0; i < WIN; i++) begin
         if (bus.busy)   busy_cnt++;
         if (bus.reject) rej_cnt++;
         if (i == 4 && extra) bus.place = 1'b1;
         @(negedge clk);
         bus.place = 1'b0;
      end
      idx = m_cur();
      if (m_over) begin
         exp_rej = 1; exp_busy = WIN;
      end else if (m_cell[idx] != 0) begin
         exp_rej = 1; exp_busy = 1;
      end else begin
         code = m_turn ? 2 : 1;
         m_cell[idx] = code;
         exp_rej = extra ? 1 : 0;
         if (m_line_win(code)) begin
            if (m_turn) m_p2win = 1'b1;
            else        m_pwin  = 1'b1;
            m_over = 1'b1; exp_busy = WIN;
         end else if (m_board_full()) begin
            m_full = 1'b1; m_over = 1'b1; exp_busy = WIN;
         end else begin
            m_turn = ~m_turn; exp_busy = 14;
         end
      end
      check_eq({tag, ".busy_cycles"},   64'(busy_cnt), 64'(exp_busy));
      check_eq({tag, ".reject_cycles"}, 64'(rej_cnt),  64'(exp_rej));
      check_flags(tag);
      check_eq({tag, ".disp_frozen"}, 64'(bus.board_disp), 64'(disp_snap));
   endtask

   task automatic do_new_game(input string tag, input bit with_place);
      @(negedge clk);
      bus.new_game = 1'b1;
      bus.place    = with_place;
      @(negedge clk);
      bus.new_game = 1'b0;
      bus.place    = 1'b0;
      model_clear();
      repeat (3) @(negedge clk);
      check_eq({tag, ".busy"},   64'(bus.busy),   64'(0));
      check_eq({tag, ".reject"}, 64'(bus.reject), 64'(0));
      check_flags(tag);
   endtask

   initial begin
      bus.place = 1'b0; bus.mv_left = 1'b0; bus.mv_right = 1'b0;
      bus.mv_up = 1'b0; bus.mv_down = 1'b0; bus.new_game = 1'b0; bus.vsync = 1'b1;
      reset = 1'b1;
      model_clear();
      disp_snap = '0;
      cur_snap  = 5'd12;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check_eq("rst.busy",        64'(bus.busy),        64'(0));
      check_eq("rst.reject",      64'(bus.reject),      64'(0));
      check_eq("rst.board_disp",  64'(bus.board_disp),  64'(0));
      check_eq("rst.cursor_disp", 64'(bus.cursor_disp), 64'(12));
      check_flags("rst");
      do_vsync("t1");

      do_place("t2", 1'b0);
      do_vsync("t2v");
      do_place("t3", 1'b0);
      do_vsync("t3v");

      do_new_game("ng1", 1'b0);
      for (int k = 0; k < 9; k++) begin
         goto_cell(row_game[k]);
         do_place("row0", k == 3);
      end
      check_eq("row0.win", 64'(bus.playerwin), 64'(1));
      do_place("over_place", 1'b0);
      do_move(1'b1, 1'b0, 1'b1, 1'b0);
      do_vsync("over_move");

      do_new_game("ng2", 1'b0);
      goto_cell(4);
      do_move(1'b0, 1'b1, 1'b0, 1'b0);
      do_vsync("wrap_right");
      goto_cell(2);
      do_move(1'b0, 1'b0, 1'b1, 1'b0);
      do_vsync("wrap_up");
      do_move(1'b1, 1'b1, 1'b0, 1'b0);
      do_vsync("cancel_lr");

      do_new_game("ng3", 1'b0);
      for (int i = 0; i < 25; i++) begin
         if (draw_pat[i] == 1) q1.push_back(i);
         else                  q2.push_back(i);
      end
      for (int k = 0; k < 13; k++) begin
         goto_cell(q1[k]);
         do_place("draw", 1'b0);
         if (k < 12) begin
            goto_cell(q2[k]);
            do_place("draw", 1'b0);
         end
      end
      check_eq("draw.full", 64'(bus.is_full), 64'(1));
      do_new_game("ng_place", 1'b1);
      do_vsync("ng_clear");

      // Reset in the middle of a scan must act immediately.
      do_place("pre_rst", 1'b0);
      do_vsync("pre_rst_v");
      goto_cell(13);
      @(negedge clk);
      bus.place = 1'b1;
      @(negedge clk);
      bus.place = 1'b0;
      repeat (4) @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check_eq("midrst.busy",        64'(bus.busy),        64'(0));
      check_eq("midrst.turn",        64'(bus.turn),        64'(0));
      check_eq("midrst.board_disp",  64'(bus.board_disp),  64'(0));
      check_eq("midrst.cursor_disp", 64'(bus.cursor_disp), 64'(12));
      @(negedge clk);
      reset = 1'b0;
      model_clear();
      disp_snap = '0;
      cur_snap  = 5'd12;
      do_vsync("post_rst");

      for (int g = 0; g < 6; g++) begin
         do_new_game("rnd_ng", 1'($urandom_range(0, 1)));
         for (int op = 0; op < 60; op++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r < 4)
               do_move(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            else if (r < 9)
               do_place("rnd", !m_over && m_cell[m_cur()] == 0 && $urandom_range(0, 3) == 0);
            else
               do_vsync("rnd_v");
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
